parking_allocator16: RTL and testbench
======================================

PARKING_ALLOCATOR16 -- requirements
Module: parking_allocator16

Interface
REQ-001 Parameter GATE_CYCLES, default 4, gate-open duration in clock cycles; legal range 1..15.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst_n  input  1  asynchronous, active-low reset.
REQ-004 arr_req  input  1  level request from the entry sensor that a car wants a slot.
REQ-005 dep_valid  input  1  single-cycle pulse that a car has left slot dep_slot.
REQ-006 dep_slot  input  4  index of the slot being vacated; qualified by dep_valid.
REQ-007 arr_grant  output  1  one-cycle pulse that a slot was allocated.
REQ-008 arr_slot  output  4  allocated slot index; valid only while arr_grant=1, otherwise 0.
REQ-009 arr_deny  output  1  one-cycle pulse that a request was refused because the lot is full.
REQ-010 gate_open  output  1  entry gate drive; high for exactly GATE_CYCLES cycles after a grant.
REQ-011 slots  output  16  registered occupancy map; bit i=1 means slot i is occupied.
REQ-012 occ_count  output  5  registered number of occupied slots, 0..16.
REQ-013 all_full  output  1  combinational: 1 when slots==16'hFFFF.
REQ-014 any_free  output  1  combinational: inverse of all_full.
REQ-015 dep_err  output  1  one-cycle pulse that dep_valid named an already-free slot.

Function
REQ-016 FSM states: IDLE, GATE. Outputs arr_grant, arr_deny and dep_err are registered.
REQ-017 In IDLE with arr_req=1 and any_free=1, the next edge sets slots[k] (k = lowest-index 0 bit of the current slots), drives arr_grant=1 and arr_slot=k for one cycle, loads the gate counter with GATE_CYCLES, and enters GATE.
REQ-018 In IDLE with arr_req=1 and all_full=1, the next edge pulses arr_deny for one cycle; state stays IDLE; deny repeats every cycle while arr_req stays high and the lot is full.
REQ-019 In GATE, gate_open=1; the counter decrements each cycle; the FSM returns to IDLE on the edge where the counter reaches 0. arr_req is ignored in GATE.
REQ-020 A second allocation cannot start until the FSM is back in IDLE: minimum grant-to-grant spacing is GATE_CYCLES+1 cycles.
REQ-021 dep_valid is honoured in any state. If slots[dep_slot]=1, that bit clears on the next edge. If slots[dep_slot]=0, slots is unchanged and dep_err pulses.
REQ-022 Allocation and departure may occur on the same edge. Allocation selects from pre-edge slots, so a slot freed on that edge is not reused until the next cycle. Both bit updates apply together.
REQ-023 occ_count updates on the same edge as slots by +1, -1, 0 (both events, or neither) and always equals popcount(slots).
REQ-024 all_full and any_free follow the registered slots with no extra latency.

Reset
REQ-025 rst_n low asynchronously forces: state=IDLE, slots=0, occ_count=0, gate counter=0, and arr_grant, arr_slot, arr_deny, gate_open and dep_err all 0.
REQ-026 Reset asserted mid-GATE drops gate_open immediately. After release, the block accepts a request on the first edge with rst_n high.

Structure
REQ-027 Package park_pkg holds NUM_SLOTS=16, SLOT_W=4, CNT_W=5 and the FSM state enum {IDLE, GATE}.
REQ-028 Lowest-free-slot selection is a combinational sub-module park_free_enc16: input slots[15:0]; outputs idx[3:0] and found.

Verification
REQ-029 Reset, then arr_req=1 held -> arr_grant pulses with arr_slot=0; gate_open is high for 4 cycles; the second grant gives arr_slot=1 exactly 5 cycles after the first; occ_count=2.
REQ-030 Fill to slots=16'hFFFF, then arr_req=1 -> arr_deny pulses each cycle, no grant, all_full=1, any_free=0, occ_count=16.
REQ-031 slots=16'h0007, dep_valid with dep_slot=1 -> slots=16'h0005; the next arrival gets arr_slot=1.
REQ-032 slots=16'h0001, dep_valid with dep_slot=5 -> dep_err pulses; slots stays 16'h0001 and occ_count stays 1.
REQ-033 slots=16'h00FF in IDLE, arr_req plus dep_valid with dep_slot=0 on the same edge -> arr_slot=8 and slots=16'h01FE.
REQ-034 rst_n pulsed low during the 2nd GATE cycle -> gate_open and slots are 0 at once; after release, a request gets arr_slot=0.

Source files
------------

// File: rtl/park_pkg.sv
// Shared constants, FSM state type and small helpers for the 16-slot parking allocator.
package park_pkg;

    localparam int NUM_SLOTS = 16;
    localparam int SLOT_W    = 4;
    localparam int CNT_W     = 5;
    localparam int GATE_W    = 4;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        GATE = 1'b1
    } park_state_e;

    // One-hot mask selecting a single slot bit.
    function automatic logic [NUM_SLOTS-1:0] slot_onehot(input logic [SLOT_W-1:0] idx);
        logic [NUM_SLOTS-1:0] m;
        m      = {NUM_SLOTS{1'b0}};
        m[idx] = 1'b1;
        return m;
    endfunction

endpackage

// File: rtl/park_free_enc16.sv
// Combinational lowest-index free-slot finder over the occupancy map.
module park_free_enc16
    import park_pkg::*;
(
    input  logic [NUM_SLOTS-1:0] slots,
    output logic [SLOT_W-1:0]    idx,
    output logic                 found
);

    // Scan from the top down so the last hit, i.e. the lowest free index, wins.
    always_comb begin
        idx   = {SLOT_W{1'b0}};
        found = 1'b0;
        for (int i = NUM_SLOTS - 1; i >= 0; i--) begin
            if (!slots[i]) begin
                idx   = SLOT_W'(i);
                found = 1'b1;
            end else begin
                found = found;
            end
        end
    end

endmodule

// File: rtl/parking_allocator16.sv
// 16-slot parking allocator: grants the lowest free slot, denies when full,
// holds the entry gate open for GATE_CYCLES cycles and tracks departures.
module parking_allocator16
    import park_pkg::*;
#(
    parameter int GATE_CYCLES = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 arr_req,
    input  logic                 dep_valid,
    input  logic [SLOT_W-1:0]    dep_slot,
    output logic                 arr_grant,
    output logic [SLOT_W-1:0]    arr_slot,
    output logic                 arr_deny,
    output logic                 gate_open,
    output logic [NUM_SLOTS-1:0] slots,
    output logic [CNT_W-1:0]     occ_count,
    output logic                 all_full,
    output logic                 any_free,
    output logic                 dep_err
);

    park_state_e          state_q, state_d;
    logic [GATE_W-1:0]    cnt_q, cnt_d;
    logic [NUM_SLOTS-1:0] slots_q, slots_d;
    logic [CNT_W-1:0]     occ_q, occ_d;
    logic                 grant_q, grant_d;
    logic [SLOT_W-1:0]    slot_q, slot_d;
    logic                 deny_q, deny_d;
    logic                 gate_q, gate_d;
    logic                 derr_q, derr_d;

    logic [SLOT_W-1:0]    free_idx_s;
    logic                 free_found_s;
    logic                 alloc_s;
    logic                 dep_ok_s;
    logic [NUM_SLOTS-1:0] set_mask_s;
    logic [NUM_SLOTS-1:0] clr_mask_s;

    park_free_enc16 u_free_enc (
        .slots (slots_q),
        .idx   (free_idx_s),
        .found (free_found_s)
    );

    // Next-state logic: allocation, departure, occupancy count and gate timing.
    always_comb begin
        alloc_s  = (state_q == IDLE) && arr_req && free_found_s;
        dep_ok_s = dep_valid && slots_q[dep_slot];

        // Allocation picks from the pre-edge map, so a slot freed this edge is not reused yet.
        set_mask_s = alloc_s  ? slot_onehot(free_idx_s) : {NUM_SLOTS{1'b0}};
        clr_mask_s = dep_ok_s ? slot_onehot(dep_slot)   : {NUM_SLOTS{1'b0}};
        slots_d    = (slots_q | set_mask_s) & ~clr_mask_s;

        case ({alloc_s, dep_ok_s})
            2'b10:   occ_d = occ_q + 5'd1;
            2'b01:   occ_d = occ_q - 5'd1;
            default: occ_d = occ_q;
        endcase

        grant_d = alloc_s;
        slot_d  = alloc_s ? free_idx_s : {SLOT_W{1'b0}};
        deny_d  = (state_q == IDLE) && arr_req && !free_found_s;
        derr_d  = dep_valid && !slots_q[dep_slot];

        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (alloc_s) begin
                    state_d = GATE;
                    cnt_d   = GATE_W'(GATE_CYCLES);
                end else begin
                    state_d = IDLE;
                    cnt_d   = cnt_q;
                end
            end
            GATE: begin
                cnt_d = cnt_q - 4'd1;
                if (cnt_q <= 4'd1) begin
                    state_d = IDLE;
                end else begin
                    state_d = GATE;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = 4'd0;
            end
        endcase

        gate_d = (state_d == GATE);
    end

    // Single state register for the FSM, occupancy map and all registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= 4'd0;
            slots_q <= 16'h0000;
            occ_q   <= 5'd0;
            grant_q <= 1'b0;
            slot_q  <= 4'd0;
            deny_q  <= 1'b0;
            gate_q  <= 1'b0;
            derr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            slots_q <= slots_d;
            occ_q   <= occ_d;
            grant_q <= grant_d;
            slot_q  <= slot_d;
            deny_q  <= deny_d;
            gate_q  <= gate_d;
            derr_q  <= derr_d;
        end
    end

    assign arr_grant = grant_q;
    assign arr_slot  = slot_q;
    assign arr_deny  = deny_q;
    assign gate_open = gate_q;
    assign slots     = slots_q;
    assign occ_count = occ_q;
    assign dep_err   = derr_q;
    assign all_full  = (slots_q == {NUM_SLOTS{1'b1}});
    assign any_free  = ~all_full;

endmodule

// File: tb/tb_parking_allocator16.sv
// Self-checking bench for parking_allocator16: constant vector table, directed
// corner sequences and a randomized phase, all through an expectation queue.
module tb_parking_allocator16;
    import park_pkg::*;

    localparam int GC = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        arr_req;
    logic        dep_valid;
    logic [3:0]  dep_slot;
    logic        arr_grant;
    logic [3:0]  arr_slot;
    logic        arr_deny;
    logic        gate_open;
    logic [15:0] slots;
    logic [4:0]  occ_count;
    logic        all_full;
    logic        any_free;
    logic        dep_err;

    parking_allocator16 #(.GATE_CYCLES(GC)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .arr_req   (arr_req),
        .dep_valid (dep_valid),
        .dep_slot  (dep_slot),
        .arr_grant (arr_grant),
        .arr_slot  (arr_slot),
        .arr_deny  (arr_deny),
        .gate_open (gate_open),
        .slots     (slots),
        .occ_count (occ_count),
        .all_full  (all_full),
        .any_free  (any_free),
        .dep_err   (dep_err)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic        grant;
        logic [3:0]  slot;
        logic        deny;
        logic        gate;
        logic [15:0] slots;
        logic [4:0]  occ;
        logic        full;
        logic        free;
        logic        derr;
    } exp_t;

    typedef struct packed {
        logic       req;
        logic       dv;
        logic [3:0] ds;
        exp_t       e;
    } vec_t;

    exp_t sbq[$];
    int   total = 0;
    int   bad   = 0;

    // Reference model state
    int          m_state;
    int          m_cnt;
    logic [15:0] m_slots;

    function automatic exp_t mk(input logic g, input logic [3:0] s, input logic d,
                                input logic go, input logic [15:0] sl, input logic [4:0] oc,
                                input logic de);
        exp_t e;
        e.grant = g;  e.slot = s;  e.deny = d;  e.gate = go;
        e.slots = sl; e.occ  = oc; e.derr = de;
        e.full  = (sl == 16'hFFFF);
        e.free  = (sl != 16'hFFFF);
        return e;
    endfunction

    task automatic model_reset();
        m_state = 0;
        m_cnt   = 0;
        m_slots = 16'h0000;
    endtask

    task automatic model_step(input logic req, input logic dv, input logic [3:0] ds, output exp_t e);
        logic [15:0] ns;
        int          k;
        e  = '0;
        ns = m_slots;
        if (dv) begin
            if (m_slots[ds]) ns[ds] = 1'b0;
            else             e.derr = 1'b1;
        end
        if (m_state == 0) begin
            if (req) begin
                if (m_slots != 16'hFFFF) begin
                    k = 0;
                    while (m_slots[k]) k++;
                    ns[k]   = 1'b1;
                    e.grant = 1'b1;
                    e.slot  = 4'(k);
                    m_state = 1;
                    m_cnt   = GC;
                end else begin
                    e.deny = 1'b1;
                end
            end
        end else begin
            m_cnt--;
            if (m_cnt == 0) m_state = 0;
        end
        m_slots = ns;
        e.gate  = (m_state == 1);
        e.slots = m_slots;
        e.occ   = 5'($countones(m_slots));
        e.full  = (m_slots == 16'hFFFF);
        e.free  = (m_slots != 16'hFFFF);
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // One clock: drive inputs, queue expectation, compare after the edge.
    task automatic cycle(input logic req, input logic dv, input logic [3:0] ds,
                         input bit use_tab, input exp_t tab);
        exp_t m, got, want;
        arr_req   = req;
        dep_valid = dv;
        dep_slot  = ds;
        model_step(req, dv, ds, m);
        sbq.push_back(use_tab ? tab : m);
        @(posedge clk);
        #1;
        want      = sbq.pop_front();
        got.grant = arr_grant; got.slot = arr_slot;  got.deny = arr_deny;
        got.gate  = gate_open; got.slots = slots;    got.occ  = occ_count;
        got.full  = all_full;  got.free  = any_free; got.derr = dep_err;
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL sb t=%0t got g=%0b s=%0d d=%0b go=%0b sl=%h oc=%0d f=%0b a=%0b e=%0b required g=%0b s=%0d d=%0b go=%0b sl=%h oc=%0d f=%0b a=%0b e=%0b",
                     $time, got.grant, got.slot, got.deny, got.gate, got.slots, got.occ, got.full, got.free, got.derr,
                     want.grant, want.slot, want.deny, want.gate, want.slots, want.occ, want.full, want.free, want.derr);
        end
    endtask

    task automatic run(input logic req, input logic dv, input logic [3:0] ds, input int n);
        for (int i = 0; i < n; i++) cycle(req, dv, ds, 1'b0, '0);
    endtask

    // Assert reset (asynchronous effect checked before any edge), then release.
    task automatic do_reset();
        rst_n     = 1'b0;
        arr_req   = 1'b0;
        dep_valid = 1'b0;
        dep_slot  = 4'd0;
        #2;
        chk("reset_outputs", {arr_grant, arr_slot, arr_deny, gate_open, slots, occ_count, dep_err, all_full, any_free},
            {1'b0, 4'd0, 1'b0, 1'b0, 16'h0000, 5'd0, 1'b0, 1'b0, 1'b1});
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        model_reset();
    endtask

    vec_t tab[7];

    initial begin
        rst_n     = 1'b0;
        arr_req   = 1'b0;
        dep_valid = 1'b0;
        dep_slot  = 4'd0;
        model_reset();

        // Basic allocation timing with hand-computed expectations
        tab[0] = '{req:1'b1, dv:1'b0, ds:4'd0, e:mk(1'b1, 4'd0, 1'b0, 1'b1, 16'h0001, 5'd1, 1'b0)};
        tab[1] = '{req:1'b1, dv:1'b0, ds:4'd0, e:mk(1'b0, 4'd0, 1'b0, 1'b1, 16'h0001, 5'd1, 1'b0)};
        tab[2] = '{req:1'b1, dv:1'b0, ds:4'd0, e:mk(1'b0, 4'd0, 1'b0, 1'b1, 16'h0001, 5'd1, 1'b0)};
        tab[3] = '{req:1'b1, dv:1'b0, ds:4'd0, e:mk(1'b0, 4'd0, 1'b0, 1'b1, 16'h0001, 5'd1, 1'b0)};
        tab[4] = '{req:1'b1, dv:1'b0, ds:4'd0, e:mk(1'b0, 4'd0, 1'b0, 1'b0, 16'h0001, 5'd1, 1'b0)};
        tab[5] = '{req:1'b1, dv:1'b0, ds:4'd0, e:mk(1'b1, 4'd1, 1'b0, 1'b1, 16'h0003, 5'd2, 1'b0)};
        tab[6] = '{req:1'b0, dv:1'b0, ds:4'd0, e:mk(1'b0, 4'd0, 1'b0, 1'b1, 16'h0003, 5'd2, 1'b0)};

        do_reset();
        for (int i = 0; i < 7; i++) cycle(tab[i].req, tab[i].dv, tab[i].ds, 1'b1, tab[i].e);

        // Fill the lot, then keep requesting: denies every cycle
        run(1'b1, 1'b0, 4'd0, 100);
        chk("full_slots", 32'(slots), 32'h0000FFFF);
        chk("full_occ", 32'(occ_count), 32'd16);
        chk("full_flags", {30'd0, all_full, any_free}, {30'd0, 1'b1, 1'b0});
        chk("full_deny", {30'd0, arr_deny, arr_grant}, {30'd0, 1'b1, 1'b0});
        run(1'b1, 1'b0, 4'd0, 3);

        // Departure frees a middle slot which is then reused
        do_reset();
        run(1'b1, 1'b0, 4'd0, 11);
        run(1'b0, 1'b0, 4'd0, 4);
        chk("three_slots", 32'(slots), 32'h00000007);
        run(1'b0, 1'b1, 4'd1, 1);
        chk("dep_slot1", 32'(slots), 32'h00000005);
        run(1'b1, 1'b0, 4'd0, 1);
        chk("reuse_slot1", {27'd0, arr_grant, arr_slot}, {27'd0, 1'b1, 4'd1});
        run(1'b0, 1'b0, 4'd0, 5);

        // Departure of a free slot flags an error and changes nothing
        do_reset();
        run(1'b1, 1'b0, 4'd0, 1);
        run(1'b0, 1'b0, 4'd0, 5);
        run(1'b0, 1'b1, 4'd5, 1);
        chk("dep_err", {15'd0, dep_err, slots}, {15'd0, 1'b1, 16'h0001});
        chk("dep_err_occ", 32'(occ_count), 32'd1);
        run(1'b0, 1'b0, 4'd0, 2);

        // Same-edge allocation and departure
        do_reset();
        run(1'b1, 1'b0, 4'd0, 36);
        run(1'b0, 1'b0, 4'd0, 4);
        chk("eight_slots", 32'(slots), 32'h000000FF);
        run(1'b1, 1'b1, 4'd0, 1);
        chk("same_edge", {12'd0, arr_slot, slots}, {12'd0, 4'd8, 16'h01FE});
        run(1'b0, 1'b0, 4'd0, 5);

        // Reset during the second gate cycle
        do_reset();
        run(1'b1, 1'b0, 4'd0, 1);
        run(1'b0, 1'b0, 4'd0, 1);
        chk("gate_before_rst", {31'd0, gate_open}, 32'd1);
        do_reset();
        run(1'b1, 1'b0, 4'd0, 1);
        chk("after_rst_grant", {27'd0, arr_grant, arr_slot}, {27'd0, 1'b1, 4'd0});
        run(1'b0, 1'b0, 4'd0, 5);

        // Randomized traffic against the model
        do_reset();
        for (int i = 0; i < 600; i++) begin
            cycle(1'($urandom_range(0, 99) < 60), 1'($urandom_range(0, 99) < 25),
                  4'($urandom_range(0, 15)), 1'b0, '0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
